// File: rtl/l1i_pkg.sv
// Shared sizes, refill state encodings and line-address helper for the L1I refill path.
package l1i_pkg;

  localparam int offsetSize          = 5;
  localparam int indexSize           = 8;
  localparam int tagSize             = 64 - (offsetSize + indexSize);
  localparam int cachelineSizeInBits = (2 ** offsetSize) * 8;
  localparam int busWidth            = 64;
  localparam int beatsPerLine        = cachelineSizeInBits / busWidth;
  localparam int beatCountWidth      = (beatsPerLine > 1) ? $clog2(beatsPerLine) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FILL  = 2'd2,
    WRITE = 2'd3
  } refill_state_e;

  function automatic logic [63:0] build_line_addr(input logic [tagSize-1:0]   tag,
                                                  input logic [indexSize-1:0] index);
    return {tag, index, {offsetSize{1'b0}}};
  endfunction

endpackage

// File: rtl/l1i_line_assembler.sv
// Beat counter plus slot-indexed line register; beat k lands in bits [k*busWidth +: busWidth].
// One-cycle load latency; no backpressure, the caller gates load.
module l1i_line_assembler
  import l1i_pkg::*;
(
  input  logic                           clock_i,
  input  logic                           reset_i,
  input  logic                           clear,
  input  logic                           load,
  input  logic [busWidth-1:0]            beat_dat,
  output logic [cachelineSizeInBits-1:0] line,
  output logic [beatCountWidth-1:0]      beat_count,
  output logic                           last_beat
);

  localparam logic [beatCountWidth-1:0] LastSlot = beatCountWidth'(beatsPerLine - 1);

  assign last_beat = (beat_count == LastSlot);

  // Saturates on the last slot so a stray extra beat can never wrap onto slot 0.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      beat_count <= '0;
    end else if (clear) begin
      beat_count <= '0;
    end else if (load && !last_beat) begin
      beat_count <= beat_count + beatCountWidth'(1);
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      line <= '0;
    end else if (load) begin
      line[beat_count*busWidth +: busWidth] <= beat_dat;
    end
  end

endmodule

// File: rtl/l1i_refill_unit.sv
// L1I refill engine: one miss at a time, line-aligned read, beat assembly, single-cycle cache update.
// Update arrives 2+beatsPerLine cycles after miss accept with an immediate ack; memory side paces via ack/data valid.
module l1i_refill_unit
  import l1i_pkg::*;
(
  input  logic                           clock_i,
  input  logic                           reset_i,
  input  logic                           flushPipeline_i,
  input  logic                           missValid_i,
  input  logic [tagSize-1:0]             missTag_i,
  input  logic [indexSize-1:0]           missIndex_i,
  input  logic [offsetSize-1:0]          missOffset_i,
  output logic                           busy_o,
  output logic                           memReq_o,
  output logic [63:0]                    memAddr_o,
  input  logic                           memAck_i,
  input  logic                           memDataValid_i,
  input  logic [busWidth-1:0]            memData_i,
  output logic                           updateEnable_o,
  output logic [cachelineSizeInBits-1:0] newCacheline_o,
  output logic [tagSize-1:0]             newTag_o,
  output logic [indexSize-1:0]           newIndex_o,
  output logic [offsetSize-1:0]          newOffset_o
);

  refill_state_e                 state_q, state_d;
  logic                          drop_q;
  logic                          busy_d, req_d, upd_d;
  logic                          miss_accept, beat_load, last_beat, drop_now;
  logic [beatCountWidth-1:0]     beat_count;

  assign miss_accept = (state_q == IDLE) && missValid_i;
  assign beat_load   = (state_q == FILL) && memDataValid_i;
  // A flush landing on the final beat still discards the line.
  assign drop_now    = drop_q || flushPipeline_i;

  l1i_line_assembler u_assembler (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .clear      (miss_accept),
    .load       (beat_load),
    .beat_dat   (memData_i),
    .line       (newCacheline_o),
    .beat_count (beat_count),
    .last_beat  (last_beat)
  );

  // State register; control outputs are registered from the next state.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q        <= IDLE;
      busy_o         <= 1'b0;
      memReq_o       <= 1'b0;
      updateEnable_o <= 1'b0;
    end else begin
      state_q        <= state_d;
      busy_o         <= busy_d;
      memReq_o       <= req_d;
      updateEnable_o <= upd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (missValid_i) state_d = REQ;
      REQ:     if (memAck_i) state_d = FILL;
      FILL:    if (beat_load && last_beat) state_d = drop_now ? IDLE : WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_d = (state_d != IDLE);
    req_d  = (state_d == REQ);
    upd_d  = (state_d == WRITE);
  end

  // The read cannot be cancelled, so a flush only marks the line for discard.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      drop_q <= 1'b0;
    end else if (miss_accept) begin
      drop_q <= 1'b0;
    end else if (flushPipeline_i && (state_q == REQ || state_q == FILL)) begin
      drop_q <= 1'b1;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      newTag_o    <= '0;
      newIndex_o  <= '0;
      newOffset_o <= '0;
      memAddr_o   <= '0;
    end else if (miss_accept) begin
      newTag_o    <= missTag_i;
      newIndex_o  <= missIndex_i;
      newOffset_o <= missOffset_i;
      memAddr_o   <= build_line_addr(missTag_i, missIndex_i);
    end
  end

  a_single_update: assert property (@(posedge clock_i) disable iff (reset_i)
    updateEnable_o |=> !updateEnable_o);

endmodule

// File: tb/tb_l1i_refill_unit.sv
// Directed refill scenarios with a scoreboard of expected cache updates.
module tb_l1i_refill_unit;
  import l1i_pkg::*;

  logic                           clock_i = 1'b0;
  logic                           reset_i;
  logic                           flushPipeline_i;
  logic                           missValid_i;
  logic [tagSize-1:0]             missTag_i;
  logic [indexSize-1:0]           missIndex_i;
  logic [offsetSize-1:0]          missOffset_i;
  logic                           busy_o;
  logic                           memReq_o;
  logic [63:0]                    memAddr_o;
  logic                           memAck_i;
  logic                           memDataValid_i;
  logic [busWidth-1:0]            memData_i;
  logic                           updateEnable_o;
  logic [cachelineSizeInBits-1:0] newCacheline_o;
  logic [tagSize-1:0]             newTag_o;
  logic [indexSize-1:0]           newIndex_o;
  logic [offsetSize-1:0]          newOffset_o;

  l1i_refill_unit dut (
    .clock_i         (clock_i),
    .reset_i         (reset_i),
    .flushPipeline_i (flushPipeline_i),
    .missValid_i     (missValid_i),
    .missTag_i       (missTag_i),
    .missIndex_i     (missIndex_i),
    .missOffset_i    (missOffset_i),
    .busy_o          (busy_o),
    .memReq_o        (memReq_o),
    .memAddr_o       (memAddr_o),
    .memAck_i        (memAck_i),
    .memDataValid_i  (memDataValid_i),
    .memData_i       (memData_i),
    .updateEnable_o  (updateEnable_o),
    .newCacheline_o  (newCacheline_o),
    .newTag_o        (newTag_o),
    .newIndex_o      (newIndex_o),
    .newOffset_o     (newOffset_o)
  );

  always #5 clock_i = ~clock_i;

  int cyc = 0;
  always @(posedge clock_i) cyc <= cyc + 1;

  typedef struct {
    logic [255:0]          line;
    logic [tagSize-1:0]    tag;
    logic [indexSize-1:0]  idx;
    logic [offsetSize-1:0] off;
    int                    cyc;
  } upd_t;

  upd_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every update strobe must match the oldest outstanding expectation.
  always @(negedge clock_i) begin : monitor
    upd_t e;
    if (reset_i === 1'b0 && updateEnable_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_update: got update tag %h at cycle %0d expected none", newTag_o, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("upd_line",   newCacheline_o,      e.line);
        chk("upd_tag",    256'(newTag_o),      256'(e.tag));
        chk("upd_index",  256'(newIndex_o),    256'(e.idx));
        chk("upd_offset", 256'(newOffset_o),   256'(e.off));
        chk("upd_cycle",  256'(cyc),           256'(e.cyc));
      end
    end
  end

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic issue_miss(input logic [tagSize-1:0] tg, input logic [indexSize-1:0] ix,
                            input logic [offsetSize-1:0] of, output int c0);
    missValid_i  = 1'b1;
    missTag_i    = tg;
    missIndex_i  = ix;
    missOffset_i = of;
    c0 = cyc;
    step();
    missValid_i = 1'b0;
  endtask

  // Entered in cycle c0+1 (REQ). upd_off/idle_off are hand-computed cycles after c0.
  task automatic serve(input logic [tagSize-1:0] tg, input logic [indexSize-1:0] ix,
                       input logic [offsetSize-1:0] of, input int c0, input int stall,
                       input logic [15:0] vpat, input int npat, input int flush_after,
                       input logic [63:0] base, input int upd_off, input int idle_off);
    upd_t        e;
    logic [63:0] exp_addr;
    int          beat;
    int          waited;
    bit          flushed;
    exp_addr = {tg, ix, 5'b00000};
    if (flush_after < 0) begin
      e.line = {base + 64'd3, base + 64'd2, base + 64'd1, base};
      e.tag  = tg;
      e.idx  = ix;
      e.off  = of;
      e.cyc  = c0 + upd_off;
      exp_q.push_back(e);
    end
    chk("req_busy", 256'(busy_o),    256'(1'b1));
    chk("req_req",  256'(memReq_o),  256'(1'b1));
    chk("req_addr", 256'(memAddr_o), 256'(exp_addr));
    for (int s = 0; s < stall; s++) begin
      memAck_i = 1'b0;
      step();
      chk("stall_req",  256'(memReq_o),  256'(1'b1));
      chk("stall_addr", 256'(memAddr_o), 256'(exp_addr));
    end
    memAck_i = 1'b1;
    step();
    memAck_i = 1'b0;
    beat = 0;
    flushed = 1'b0;
    for (int p = 0; p < npat; p++) begin
      memDataValid_i  = vpat[p];
      memData_i       = vpat[p] ? base + 64'(beat) : 64'hDEAD_BEEF_DEAD_BEEF;
      flushPipeline_i = (flush_after >= 0) && (beat == flush_after + 1) && !flushed;
      if (flushPipeline_i) flushed = 1'b1;
      if (vpat[p]) beat++;
      step();
    end
    memDataValid_i  = 1'b0;
    flushPipeline_i = 1'b0;
    waited = 0;
    while (busy_o !== 1'b0 && waited < 40) begin
      step();
      waited++;
    end
    chk("idle_cycle", 256'(cyc), 256'(c0 + idle_off));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int c0;
    int c1;
    reset_i         = 1'b1;
    flushPipeline_i = 1'b0;
    missValid_i     = 1'b0;
    missTag_i       = '0;
    missIndex_i     = '0;
    missOffset_i    = '0;
    memAck_i        = 1'b0;
    memDataValid_i  = 1'b0;
    memData_i       = '0;
    #1;
    chk("rst_busy",  256'(busy_o),         256'(0));
    chk("rst_req",   256'(memReq_o),       256'(0));
    chk("rst_addr",  256'(memAddr_o),      256'(0));
    chk("rst_upd",   256'(updateEnable_o), 256'(0));
    chk("rst_line",  newCacheline_o,       256'(0));
    chk("rst_tag",   256'(newTag_o),       256'(0));
    chk("rst_index", 256'(newIndex_o),     256'(0));
    chk("rst_off",   256'(newOffset_o),    256'(0));
    @(posedge clock_i);
    @(posedge clock_i);
    #3 reset_i = 1'b0;
    step();

    // Basic refill: update in cycle 6, idle in cycle 7.
    issue_miss(51'h1234, 8'h5A, 5'h0C, c0);
    serve(51'h1234, 8'h5A, 5'h0C, c0, 0, 16'h000F, 4, -1, 64'hA0A0_A0A0_0000_0000, 6, 7);

    // Ack stalled 5 cycles: everything slips by 5.
    issue_miss(51'h7_0000_0000_BEEF, 8'hC3, 5'h1F, c0);
    serve(51'h7_0000_0000_BEEF, 8'hC3, 5'h1F, c0, 5, 16'h000F, 4, -1, 64'hB1B1_0000_0000_0010, 11, 12);

    // Gapped beats 1,0,0,1,1,0,1: last beat in cycle 8, update in 9.
    issue_miss(51'h00ABC, 8'h01, 5'h04, c0);
    serve(51'h00ABC, 8'h01, 5'h04, c0, 0, 16'b0000_0000_0101_1001, 7, -1, 64'hC2C2_C2C2_0000_0100, 9, 10);

    // Flush after beat 1: no update, busy falls in cycle 6.
    issue_miss(51'h5555, 8'hFF, 5'h10, c0);
    serve(51'h5555, 8'hFF, 5'h10, c0, 0, 16'h000F, 4, 1, 64'hD3D3_0000_0000_1000, 6, 6);

    // Miss held from cycle 2 through 7: ignored while busy, accepted in cycle 7.
    fork
      begin
        issue_miss(51'h1111, 8'h22, 5'h03, c0);
        serve(51'h1111, 8'h22, 5'h03, c0, 0, 16'h000F, 4, -1, 64'hE4E4_0000_0000_0000, 6, 7);
      end
      begin
        step();
        step();
        missValid_i  = 1'b1;
        missTag_i    = 51'h2222;
        missIndex_i  = 8'h33;
        missOffset_i = 5'h07;
        repeat (6) step();
        missValid_i = 1'b0;
      end
    join
    c1 = c0 + 7;
    serve(51'h2222, 8'h33, 5'h07, c1, 0, 16'h000F, 4, -1, 64'hF5F5_0000_0000_0000, 6, 7);

    // Async reset mid-FILL, off a clock edge.
    issue_miss(51'h0F0F, 8'h44, 5'h08, c0);
    memAck_i = 1'b1;
    step();
    memAck_i = 1'b0;
    memDataValid_i = 1'b1;
    memData_i = 64'h5555_5555_5555_5555;
    step();
    memData_i = 64'h6666_6666_6666_6666;
    #2 reset_i = 1'b1;
    #1;
    chk("arst_busy",  256'(busy_o),         256'(0));
    chk("arst_req",   256'(memReq_o),       256'(0));
    chk("arst_addr",  256'(memAddr_o),      256'(0));
    chk("arst_upd",   256'(updateEnable_o), 256'(0));
    chk("arst_line",  newCacheline_o,       256'(0));
    chk("arst_tag",   256'(newTag_o),       256'(0));
    chk("arst_index", 256'(newIndex_o),     256'(0));
    chk("arst_off",   256'(newOffset_o),    256'(0));
    step();
    #2;
    reset_i = 1'b0;
    memDataValid_i = 1'b0;
    step();
    issue_miss(51'h3C3C, 8'h99, 5'h15, c0);
    serve(51'h3C3C, 8'h99, 5'h15, c0, 0, 16'h000F, 4, -1, 64'h1234_5678_0000_0000, 6, 7);

    repeat (3) step();
    chk("queue_empty", 256'(exp_q.size()), 256'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
